// File: rtl/half_adder_pkg.sv
// ---------------------------------------------------------------------------
// half_adder_pkg
// Shared definitions for the half_adder_unit slice.
//   DEFAULT_WIDTH / DEFAULT_CNT_W : default lane count and counter width
//   ha_result_t                   : per-lane result {sum, carry}
//   ha_bit(a, b)                  : single-bit half adder returning ha_result_t
// ---------------------------------------------------------------------------
package half_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

    // One lane of the adder: XOR gives the sum, AND gives the carry.
    function automatic ha_result_t ha_bit(input logic a, input logic b);
        ha_result_t res;
        res.sum   = a ^ b;
        res.carry = a & b;
        return res;
    endfunction

endpackage

// File: rtl/half_adder_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : count up by one on this edge (ignored once saturated)
//   clr   : synchronous clear, wins over inc
//   count : current counter value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear has priority; increments stop once every bit is set so the
    // value never rolls back over to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/half_adder_unit.sv
// ---------------------------------------------------------------------------
// half_adder_unit
// WIDTH independent half-adder lanes plus a saturating count of accepted
// transfers that produced at least one carry.
//
// Build option: define HALF_ADDER_OUT_REG_EN to register sum/carry/out_valid
// (1-cycle latency, reset to 0). Without it the data path is combinational
// and out_valid follows in_valid directly.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : qualifies a/b
//   a, b      : WIDTH-bit addends, lane i = bit i
//   sum       : per-lane a ^ b
//   carry     : per-lane a & b
//   out_valid : qualifies sum/carry
//   carry_cnt : saturating count of valid transfers with any carry set
//   cnt_clr   : synchronous clear of carry_cnt
// ---------------------------------------------------------------------------
module half_adder_unit
    import half_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    input  logic             cnt_clr
);

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_carry;
    logic             carry_event;

    // Each lane is evaluated in isolation, so an unknown on one input bit
    // cannot leak into any other lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_result_t lane_res;
        assign lane_res      = ha_bit(a[i], b[i]);
        assign lane_sum[i]   = lane_res.sum;
        assign lane_carry[i] = lane_res.carry;
    end

    // The counter looks at the input side so both builds count the same
    // events on the same edge.
    assign carry_event = in_valid && (|lane_carry);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_carry_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (carry_event),
        .clr   (cnt_clr),
        .count (carry_cnt)
    );

`ifdef HALF_ADDER_OUT_REG_EN
    // Results are captured only on valid edges; an idle edge drops
    // out_valid but leaves the last sum/carry visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= lane_sum;
            carry     <= lane_carry;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
`else
    assign sum       = lane_sum;
    assign carry     = lane_carry;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// ---------------------------------------------------------------------------
// tb_half_adder_unit
// Drives an 8-lane unit (16-bit counter) and a 1-lane unit (2-bit counter)
// from the same stimulus; the narrow unit sees only lane 0. Expected values
// come from fixed vectors and an arithmetic reference model. Handles both
// the default build and HALF_ADDER_OUT_REG_EN.
// ---------------------------------------------------------------------------
module tb_half_adder_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic [7:0]  sum8, carry8;
    logic        out_valid8;
    logic [15:0] cnt8;

    logic        sum1, carry1, out_valid1;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_cnt8 = 0;
    int         m_cnt1 = 0;
    logic [7:0] m_sum = '0;
    logic [7:0] m_carry = '0;
    logic       m_valid = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic [7:0] exp_carry;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    half_adder_unit #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum8),
        .carry     (carry8),
        .out_valid (out_valid8),
        .carry_cnt (cnt8),
        .cnt_clr   (cnt_clr)
    );

    half_adder_unit #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a[0]),
        .b         (b[0]),
        .sum       (sum1),
        .carry     (carry1),
        .out_valid (out_valid1),
        .carry_cnt (cnt1),
        .cnt_clr   (cnt_clr)
    );

    // Add the two bits of each lane as integers: low bit is sum, high is carry.
    function automatic void ref_add(input logic [7:0] x, input logic [7:0] y,
                                    output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = (x[i] ? 1 : 0) + (y[i] ? 1 : 0);
            s[i] = (t % 2) == 1;
            c[i] = t >= 2;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_cnt8  = 0;
        m_cnt1  = 0;
        m_sum   = '0;
        m_carry = '0;
        m_valid = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic modelEdge();
        logic [7:0] s, c;
        ref_add(a, b, s, c);
        if (cnt_clr) begin
            m_cnt8 = 0;
            m_cnt1 = 0;
        end else if (in_valid) begin
            if (c != 0 && m_cnt8 < 65535) m_cnt8++;
            if (c[0] && m_cnt1 < 3) m_cnt1++;
        end
        if (in_valid) begin
            m_sum   = s;
            m_carry = c;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll(input string tag);
        logic [7:0] es, ec;
        logic       ev;
`ifdef HALF_ADDER_OUT_REG_EN
        es = m_sum;
        ec = m_carry;
        ev = m_valid;
`else
        ref_add(a, b, es, ec);
        ev = in_valid;
`endif
        checkOutput({tag, ".sum8"}, 32'(sum8), 32'(es));
        checkOutput({tag, ".carry8"}, 32'(carry8), 32'(ec));
        checkOutput({tag, ".valid8"}, 32'(out_valid8), 32'(ev));
        checkOutput({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt8));
        checkOutput({tag, ".sum1"}, 32'(sum1), 32'(es[0]));
        checkOutput({tag, ".carry1"}, 32'(carry1), 32'(ec[0]));
        checkOutput({tag, ".valid1"}, 32'(out_valid1), 32'(ev));
        checkOutput({tag, ".cnt1"}, 32'(cnt1), 32'(m_cnt1));
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // view shortly after, then check everything just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] aa,
                                 input logic [7:0] bb, input logic clr,
                                 input string tag);
        @(negedge clk);
        in_valid = v;
        a        = aa;
        b        = bb;
        cnt_clr  = clr;
        #1;
`ifndef HALF_ADDER_OUT_REG_EN
        checkAll({tag, ".pre"});
`endif
        @(posedge clk);
        #1;
        modelEdge();
        checkAll(tag);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h00, 8'h01, 8'h01, 8'h00};
        vecs[2] = '{8'h01, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{8'h01, 8'h01, 8'h00, 8'h01};
        vecs[4] = '{8'hF0, 8'h3C, 8'hCC, 8'h30};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00};

        // Reset state
        modelReset();
        #2;
        checkAll("reset");
        checkOutput("reset.cnt8_zero", 32'(cnt8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed vectors: truth table and lane independence
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.tbl_sum", i), 32'(sum8), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("vec%0d.tbl_carry", i), 32'(carry8), 32'(vecs[i].exp_carry));
            checkOutput($sformatf("vec%0d.tbl_sum1", i), 32'(sum1), 32'(vecs[i].exp_sum[0]));
        end

        // Asynchronous reset between edges clears the counter at once
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset.cnt8", 32'(cnt8), 32'd0);
        checkOutput("midreset.cnt1", 32'(cnt1), 32'd0);
`ifdef HALF_ADDER_OUT_REG_EN
        checkOutput("midreset.sum8", 32'(sum8), 32'd0);
        checkOutput("midreset.carry8", 32'(carry8), 32'd0);
        checkOutput("midreset.valid8", 32'(out_valid8), 32'd0);
`endif
        #1;
        rst_n = 1'b1;

        // 5 carry cycles interleaved with 3 carry-free cycles
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1 && i < 7)
                applyStimulus(1'b1, 8'h01, 8'h00, 1'b0, "cnt_nocarry");
            else
                applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, "cnt_carry");
        end
        checkOutput("cnt.five", 32'(cnt8), 32'd5);
        checkOutput("cnt.sat1", 32'(cnt1), 32'd3);

        // Clear wins over a simultaneous carry
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b1, "clr");
        checkOutput("clr.cnt8", 32'(cnt8), 32'd0);
        checkOutput("clr.cnt1", 32'(cnt1), 32'd0);

        // Six carry cycles saturate the 2-bit counter
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 8'h81, 8'h81, 1'b0, "sat");
        checkOutput("sat.cnt1", 32'(cnt1), 32'd3);
        checkOutput("sat.cnt8", 32'(cnt8), 32'd6);

        // Invalid carry cycle does not count; registered outputs hold
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, "hold_a");
        applyStimulus(1'b0, 8'h02, 8'h03, 1'b0, "hold_b");
        checkOutput("hold.valid8", 32'(out_valid8), 32'd0);
        checkOutput("hold.cnt8", 32'(cnt8), 32'd7);
`ifdef HALF_ADDER_OUT_REG_EN
        checkOutput("hold.sum8", 32'(sum8), 32'h00);
        checkOutput("hold.carry8", 32'(carry8), 32'h01);
`else
        checkOutput("hold.sum8", 32'(sum8), 32'h01);
        checkOutput("hold.carry8", 32'(carry8), 32'h02);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 15) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
